// File: rtl/io_pkg.sv
// Shared IO defaults used by the switch debouncer and display drivers.
// Keeps board-level timing and width constants in one place.
package io_pkg;

  localparam int IO_SW_WIDTH    = 32;
  localparam int IO_TICK_DIV    = 50000;
  localparam int IO_STABLE_CNT  = 4;
  localparam int IO_SYNC_STAGES = 2;

endpackage

// File: rtl/io_tick_gen.sv
// Free-running sample tick: one registered pulse every TICK_DIV cycles.
// Shared by IO blocks that need a slow, glitch-free timing strobe.
module io_tick_gen
  import io_pkg::*;
#(
  parameter int TICK_DIV = IO_TICK_DIV
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] PRE  = TW'(TICK_DIV - 2);

  logic [TW-1:0] tcnt;

  // o_tick is set one edge early so it is high while tcnt==LAST
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tcnt   <= '0;
      o_tick <= 1'b0;
    end else begin
      tcnt   <= (tcnt == LAST) ? '0 : tcnt + 1'b1;
      o_tick <= (tcnt == PRE);
    end
  end

endmodule

// File: rtl/io_sw_debounce.sv
// Switch conditioning: synchronise raw pins, debounce each bit on a
// shared tick, and emit per-bit rise/fall pulses.
module io_sw_debounce
  import io_pkg::*;
#(
  parameter int WIDTH       = IO_SW_WIDTH,
  parameter int SYNC_STAGES = IO_SYNC_STAGES,
  parameter int TICK_DIV    = IO_TICK_DIV,
  parameter int STABLE_CNT  = IO_STABLE_CNT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_sw_changed,
  output logic             o_tick
);

  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CNT - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] flip;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= i_sw_raw;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  io_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (o_tick)
  );

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [CW-1:0] cnt_q;
    logic          differ;

    assign differ  = sync[b] ^ o_sw[b];
    assign flip[b] = o_tick & differ & (cnt_q == CMAX);

    // any agreeing sample restarts the run
    always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)
        cnt_q <= '0;
      else if (o_tick) begin
        if (!differ || cnt_q == CMAX)
          cnt_q <= '0;
        else
          cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_sw         <= '0;
      o_sw_rise    <= '0;
      o_sw_fall    <= '0;
      o_sw_changed <= 1'b0;
    end else begin
      o_sw         <= o_sw ^ flip;
      o_sw_rise    <= flip & ~o_sw;
      o_sw_fall    <= flip & o_sw;
      o_sw_changed <= |flip;
    end
  end

endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with a short tick and count.
// Outputs are sampled on the falling clock edge.
module tb_io_sw_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raw = 4'h0;
  logic [3:0] o_sw, o_sw_rise, o_sw_fall;
  logic       o_sw_changed, o_tick;

  int n_vec = 0;
  int n_bad = 0;

  io_sw_debounce #(
    .WIDTH       (4),
    .SYNC_STAGES (2),
    .TICK_DIV    (4),
    .STABLE_CNT  (3)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_sw_raw     (raw),
    .o_sw         (o_sw),
    .o_sw_rise    (o_sw_rise),
    .o_sw_fall    (o_sw_fall),
    .o_sw_changed (o_sw_changed),
    .o_tick       (o_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    assert ((o_sw_rise & o_sw_fall) == 4'h0)
    else begin
      n_bad++;
      $display("FAIL rise_fall_overlap: got %h want 0",
               o_sw_rise & o_sw_fall);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  int         chg_at, rise_at, nchg, nrise, nfall, nchgd;
  logic [3:0] rise_val, fall_val, prev;

  task automatic clear_stats();
    chg_at = -1; rise_at = -1;
    nchg = 0; nrise = 0; nfall = 0; nchgd = 0;
    rise_val = 4'h0; fall_val = 4'h0;
    prev = o_sw;
  endtask

  task automatic step(input int i);
    @(negedge clk);
    if (o_sw !== prev) begin
      nchg++;
      chg_at = i;
      prev = o_sw;
    end
    if (o_sw_rise != 4'h0) begin
      nrise++;
      rise_val = o_sw_rise;
      rise_at = i;
    end
    if (o_sw_fall != 4'h0) begin
      nfall++;
      fall_val = o_sw_fall;
    end
    if (o_sw_changed) nchgd++;
  endtask

  task automatic wait_tick();
    logic found;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = o_tick;
    end
    check("tick_found", 32'(found), 32'd1);
  endtask

  int first_tick;

  initial begin
    // 1: reset with all switches high, then release
    raw = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_sw", 32'(o_sw), 32'h0);
    check("rst_pulses",
          32'({o_sw_rise, o_sw_fall, o_sw_changed, o_tick}), 32'h0);
    rst_n = 1'b1;
    clear_stats();
    first_tick = -1;
    for (int i = 1; i <= 20; i++) begin
      step(i);
      if (o_tick && first_tick < 0) first_tick = i;
    end
    check("t1_first_tick", 32'(first_tick), 32'd3);
    check("t1_chg_at", 32'(chg_at), 32'd12);
    check("t1_sw", 32'(o_sw), 32'hF);
    check("t1_nrise", 32'(nrise), 32'd1);
    check("t1_rise_val", 32'(rise_val), 32'hF);
    check("t1_rise_at", 32'(rise_at), 32'd12);
    check("t1_nchgd", 32'(nchgd), 32'd1);
    check("t1_nfall", 32'(nfall), 32'd0);

    // 2: single bit rise from zero
    rst_n = 1'b0;
    raw = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    raw = 4'h1;
    clear_stats();
    for (int i = 1; i <= 20; i++) step(i);
    check("t2_lat_range", 32'(chg_at >= 11 && chg_at <= 15), 32'd1);
    check("t2_chg_at", 32'(chg_at), 32'd12);
    check("t2_sw", 32'(o_sw), 32'h1);
    check("t2_rise_val", 32'(rise_val), 32'h1);
    check("t2_nrise", 32'(nrise), 32'd1);
    check("t2_nchgd", 32'(nchgd), 32'd1);

    // 3: bounce on bit1 aligned to ticks
    wait_tick();
    clear_stats();
    for (int i = 1; i <= 30; i++) begin
      step(i);
      if (i == 1) raw[1] = 1'b1;
      if (i == 5) raw[1] = 1'b0;
      if (i == 9) raw[1] = 1'b1;
    end
    check("t3_chg_at", 32'(chg_at), 32'd21);
    check("t3_nrise", 32'(nrise), 32'd1);
    check("t3_rise_val", 32'(rise_val), 32'h2);
    check("t3_sw", 32'(o_sw), 32'h3);
    check("t3_nfall", 32'(nfall), 32'd0);

    // 4: all bits fall together
    raw = 4'hF;
    repeat (20) @(negedge clk);
    check("t4_pre_sw", 32'(o_sw), 32'hF);
    clear_stats();
    raw = 4'h0;
    for (int i = 1; i <= 20; i++) step(i);
    check("t4_nchg", 32'(nchg), 32'd1);
    check("t4_nfall", 32'(nfall), 32'd1);
    check("t4_fall_val", 32'(fall_val), 32'hF);
    check("t4_nchgd", 32'(nchgd), 32'd1);
    check("t4_nrise", 32'(nrise), 32'd0);
    check("t4_sw", 32'(o_sw), 32'h0);

    // 5: reset in the middle of a bit2 count
    raw = 4'h1;
    repeat (20) @(negedge clk);
    check("t5_pre_sw", 32'(o_sw), 32'h1);
    wait_tick();
    clear_stats();
    for (int i = 1; i <= 9; i++) begin
      step(i);
      if (i == 1) raw = 4'h5;
    end
    check("t5_mid_sw", 32'(o_sw), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_async_sw", 32'(o_sw), 32'h0);
    check("t5_async_pulses",
          32'({o_sw_rise, o_sw_fall, o_sw_changed, o_tick}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    for (int i = 1; i <= 20; i++) step(i);
    check("t5_chg_at", 32'(chg_at), 32'd12);
    check("t5_sw", 32'(o_sw), 32'h5);
    check("t5_rise_val", 32'(rise_val), 32'h5);

    // 6: sub-cycle glitches on bit3
    clear_stats();
    for (int i = 1; i <= 20; i++) begin
      step(i);
      if (i == 2 || i == 9) begin
        #1 raw[3] = 1'b1;
        #2 raw[3] = 1'b0;
      end
    end
    check("t6_nchg", 32'(nchg), 32'd0);
    check("t6_pulses", 32'(nrise + nfall + nchgd), 32'd0);
    check("t6_sw", 32'(o_sw), 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
